// File: rtl/axil_slave_regfile.sv
// AXI4-Lite slave register bank: NUM_REGS x 32-bit registers with byte-strobe
// writes, independent write and read state machines, all outputs registered.
// Optional feature macro: AXIL_PROT_CHECK_EN (reject unprivileged accesses).
module axil_slave_regfile #(
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 32
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              AWVALID,
    output logic              AWREADY,
    input  logic [ADDR_W-1:0] AWADDR,
    input  logic [2:0]        AWPROT,
    input  logic              WVALID,
    output logic              WREADY,
    input  logic [31:0]       WDATA,
    input  logic [3:0]        WSTRB,
    output logic              BVALID,
    input  logic              BREADY,
    output logic [1:0]        BRESP,
    input  logic              ARVALID,
    output logic              ARREADY,
    input  logic [ADDR_W-1:0] ARADDR,
    input  logic [2:0]        ARPROT,
    output logic              RVALID,
    input  logic              RREADY,
    output logic [31:0]       RDATA,
    output logic [1:0]        RRESP,
    output logic [31:0]       o_REG0
);

    localparam int IDX_W = $clog2(NUM_REGS);
    localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(NUM_REGS * 4);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic {W_IDLE, W_RESP} wState_t;
    typedef enum logic {R_IDLE, R_DATA} rState_t;

    logic [31:0] r_regs [NUM_REGS];

    // ---------------- write side ----------------
    wState_t           r_wState, w_wStateNext;
    logic              r_awready, r_wready, r_bvalid;
    logic [1:0]        r_bresp;
    logic [ADDR_W-1:0] r_awaddr;
    logic [31:0]       r_wdata;
    logic [3:0]        r_wstrb;

    logic              w_awHs, w_wHs, w_awHave, w_wHave, w_commit;
    logic [ADDR_W-1:0] w_wrAddr;
    logic [31:0]       w_wrData;
    logic [3:0]        w_wrStrb;
    logic [IDX_W-1:0]  w_wrIdx;
    logic              w_wrInRange, w_wrPriv, w_wrApply;
    logic              w_awreadyNext, w_wreadyNext, w_bvalidNext;
    logic [1:0]        w_brespNext;

    // ---------------- read side ----------------
    rState_t           r_rState, w_rStateNext;
    logic              r_arready, r_rvalid;
    logic [31:0]       r_rdata;
    logic [1:0]        r_rresp;

    logic              w_arHs, w_rdPriv, w_rdOk;
    logic [IDX_W-1:0]  w_rdIdx;
    logic              w_arreadyNext, w_rvalidNext;
    logic [31:0]       w_rdataNext;
    logic [1:0]        w_rrespNext;

    // A channel counts as "held" once its READY has dropped after a capture,
    // so the commit fires on whichever edge delivers the second half.
    assign w_awHs   = (r_wState == W_IDLE) && AWVALID && r_awready;
    assign w_wHs    = (r_wState == W_IDLE) && WVALID && r_wready;
    assign w_awHave = w_awHs || !r_awready;
    assign w_wHave  = w_wHs || !r_wready;
    assign w_commit = (r_wState == W_IDLE) && w_awHave && w_wHave && (w_awHs || w_wHs);

    assign w_wrAddr    = w_awHs ? AWADDR : r_awaddr;
    assign w_wrData    = w_wHs ? WDATA : r_wdata;
    assign w_wrStrb    = w_wHs ? WSTRB : r_wstrb;
    assign w_wrIdx     = w_wrAddr[2 +: IDX_W];
    assign w_wrInRange = (w_wrAddr < ADDR_LIMIT);
    assign w_wrApply   = w_wrInRange && w_wrPriv;

    assign w_arHs  = (r_rState == R_IDLE) && ARVALID && r_arready;
    assign w_rdIdx = ARADDR[2 +: IDX_W];
    assign w_rdOk  = (ARADDR < ADDR_LIMIT) && w_rdPriv;

`ifdef AXIL_PROT_CHECK_EN
    logic r_awprot0;
    logic w_unusedProt;
    assign w_wrPriv     = w_awHs ? AWPROT[0] : r_awprot0;
    assign w_rdPriv     = ARPROT[0];
    assign w_unusedProt = &{1'b0, AWPROT[2:1], ARPROT[2:1]};

    // Keep the privilege bit of a write address that arrived ahead of its data
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            r_awprot0 <= 1'b0;
        else if (w_awHs)
            r_awprot0 <= AWPROT[0];
    end
`else
    logic w_unusedProt;
    assign w_wrPriv     = 1'b1;
    assign w_rdPriv     = 1'b1;
    assign w_unusedProt = &{1'b0, AWPROT, ARPROT};
`endif

    // Write FSM state register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            r_wState <= W_IDLE;
        else
            r_wState <= w_wStateNext;
    end

    // Write FSM next-state: respond after commit, return once B is accepted
    always_comb begin
        w_wStateNext = r_wState;
        case (r_wState)
            W_IDLE: if (w_commit) w_wStateNext = W_RESP;
            W_RESP: if (BREADY)   w_wStateNext = W_IDLE;
            default:              w_wStateNext = W_IDLE;
        endcase
    end

    // Write FSM output decode: next values of the registered handshake outputs
    always_comb begin
        w_awreadyNext = r_awready;
        w_wreadyNext  = r_wready;
        w_bvalidNext  = r_bvalid;
        w_brespNext   = r_bresp;
        case (r_wState)
            W_IDLE: begin
                w_awreadyNext = r_awready && !w_awHs;
                w_wreadyNext  = r_wready && !w_wHs;
                if (w_commit) begin
                    w_bvalidNext = 1'b1;
                    w_brespNext  = w_wrApply ? RESP_OKAY : RESP_SLVERR;
                end
            end
            W_RESP: begin
                if (BREADY) begin
                    w_bvalidNext  = 1'b0;
                    w_awreadyNext = 1'b1;
                    w_wreadyNext  = 1'b1;
                end
            end
            default: begin
                w_bvalidNext  = 1'b0;
                w_awreadyNext = 1'b1;
                w_wreadyNext  = 1'b1;
            end
        endcase
    end

    // Registered write-channel outputs and the captured address/data/strobe
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_awready <= 1'b1;
            r_wready  <= 1'b1;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_awaddr  <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
        end else begin
            r_awready <= w_awreadyNext;
            r_wready  <= w_wreadyNext;
            r_bvalid  <= w_bvalidNext;
            r_bresp   <= w_brespNext;
            if (w_awHs)
                r_awaddr <= AWADDR;
            if (w_wHs) begin
                r_wdata <= WDATA;
                r_wstrb <= WSTRB;
            end
        end
    end

    // Register bank: strobed byte lanes update only on an allowed commit
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++)
                r_regs[i] <= '0;
        end else if (w_commit && w_wrApply) begin
            for (int b = 0; b < 4; b++)
                if (w_wrStrb[b])
                    r_regs[w_wrIdx][8*b +: 8] <= w_wrData[8*b +: 8];
        end
    end

    // Read FSM state register
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET)
            r_rState <= R_IDLE;
        else
            r_rState <= w_rStateNext;
    end

    // Read FSM next-state: hold data after AR until R is accepted
    always_comb begin
        w_rStateNext = r_rState;
        case (r_rState)
            R_IDLE: if (w_arHs) w_rStateNext = R_DATA;
            R_DATA: if (RREADY) w_rStateNext = R_IDLE;
            default:            w_rStateNext = R_IDLE;
        endcase
    end

    // Read FSM output decode; the bank is sampled before any same-edge write lands
    always_comb begin
        w_arreadyNext = r_arready;
        w_rvalidNext  = r_rvalid;
        w_rdataNext   = r_rdata;
        w_rrespNext   = r_rresp;
        case (r_rState)
            R_IDLE: begin
                if (w_arHs) begin
                    w_arreadyNext = 1'b0;
                    w_rvalidNext  = 1'b1;
                    w_rdataNext   = w_rdOk ? r_regs[w_rdIdx] : 32'h0;
                    w_rrespNext   = w_rdOk ? RESP_OKAY : RESP_SLVERR;
                end
            end
            R_DATA: begin
                if (RREADY) begin
                    w_arreadyNext = 1'b1;
                    w_rvalidNext  = 1'b0;
                end
            end
            default: begin
                w_arreadyNext = 1'b1;
                w_rvalidNext  = 1'b0;
            end
        endcase
    end

    // Registered read-channel outputs
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= RESP_OKAY;
        end else begin
            r_arready <= w_arreadyNext;
            r_rvalid  <= w_rvalidNext;
            r_rdata   <= w_rdataNext;
            r_rresp   <= w_rrespNext;
        end
    end

    assign AWREADY = r_awready;
    assign WREADY  = r_wready;
    assign BVALID  = r_bvalid;
    assign BRESP   = r_bresp;
    assign ARREADY = r_arready;
    assign RVALID  = r_rvalid;
    assign RDATA   = r_rdata;
    assign RRESP   = r_rresp;
    assign o_REG0  = r_regs[0];

endmodule

// File: tb/tb_axil_slave_regfile.sv
// Self-checking bench for axil_slave_regfile (NUM_REGS=8, ADDR_W=32).
// Expected responses are queued when a transfer is driven and compared by a
// monitor when the DUT completes the B or R handshake.
module tb_axil_slave_regfile;

    localparam int NREGS = 8;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RREADY;
    logic [31:0] AWADDR, ARADDR, WDATA, RDATA, o_REG0;
    logic [2:0]  AWPROT, ARPROT;
    logic [3:0]  WSTRB;
    logic [1:0]  BRESP, RRESP;

    int checks = 0;
    int errors = 0;

    logic [31:0] model [NREGS];
    logic [1:0]  bq [$];
    logic [33:0] rq [$];

    axil_slave_regfile #(.NUM_REGS(NREGS), .ADDR_W(32)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWPROT(AWPROT),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WSTRB(WSTRB),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARPROT(ARPROT),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RRESP(RRESP),
        .o_REG0(o_REG0)
    );

    always #5 ACLK = ~ACLK;

    // Single comparison point: counts every check and reports mismatches
    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic logic wrOk(input logic [31:0] addr, input logic [2:0] prot);
        logic ok;
        ok = (addr < 32'(NREGS * 4));
`ifdef AXIL_PROT_CHECK_EN
        ok = ok && prot[0];
`else
        if (prot == 3'b111) ok = ok;
`endif
        return ok;
    endfunction

    function automatic logic [33:0] expectRead(input logic [31:0] addr, input logic [2:0] prot);
        if (wrOk(addr, prot))
            return {2'b00, model[addr[4:2]]};
        return {2'b10, 32'h0};
    endfunction

    // Scoreboard monitor: compares completed responses against queued expectations
    always @(negedge ACLK) begin
        if (!ARESET) begin
            if (BVALID && BREADY) begin
                if (bq.size() == 0) checkOutput("b_unexpected", 64'(1), 64'(0));
                else checkOutput("bresp", 64'(BRESP), 64'(bq.pop_front()));
            end
            if (RVALID && RREADY) begin
                if (rq.size() == 0) checkOutput("r_unexpected", 64'(1), 64'(0));
                else checkOutput("rresp_rdata", 64'({RRESP, RDATA}), 64'(rq.pop_front()));
            end
        end
    end

    task automatic writeTxn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            input int awDelay, input int wDelay, input int bHold, input logic [2:0] prot);
        logic ok, awDone, wDone, awHs, wHs, hs;
        logic [1:0] expResp;
        int cyc;
        ok = wrOk(addr, prot);
        expResp = ok ? 2'b00 : 2'b10;
        bq.push_back(expResp);
        AWADDR = addr; AWPROT = prot; WDATA = data; WSTRB = strb;
        BREADY = (bHold == 0);
        awDone = 0; wDone = 0; cyc = 0;
        while (!(awDone && wDone) && cyc < 50) begin
            AWVALID = (cyc >= awDelay) && !awDone;
            WVALID  = (cyc >= wDelay) && !wDone;
            @(negedge ACLK);
            awHs = AWVALID && AWREADY;
            wHs  = WVALID && WREADY;
            @(posedge ACLK); #1;
            if (awHs) awDone = 1;
            if (wHs)  wDone = 1;
            if (awDone != wDone) begin
                checkOutput("half_ready_low", 64'(awDone ? AWREADY : WREADY), 64'(0));
                checkOutput("half_no_b", 64'(BVALID), 64'(0));
            end
            cyc++;
        end
        AWVALID = 0; WVALID = 0;
        if (!(awDone && wDone)) checkOutput("aw_w_timeout", 64'(0), 64'(1));
        if (ok)
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[addr[4:2]][8*b +: 8] = data[8*b +: 8];
        checkOutput("b_latency", 64'(BVALID), 64'(1));
        checkOutput("awready_low", 64'(AWREADY), 64'(0));
        checkOutput("wready_low", 64'(WREADY), 64'(0));
        for (int i = 0; i < bHold; i++) begin
            @(negedge ACLK);
            checkOutput("b_hold_valid", 64'(BVALID), 64'(1));
            checkOutput("b_hold_resp", 64'(BRESP), 64'(expResp));
            checkOutput("b_hold_ready", 64'({AWREADY, WREADY}), 64'(0));
        end
        if (bHold > 0) begin
            @(posedge ACLK); #1;
            BREADY = 1;
        end
        hs = 0; cyc = 0;
        while (!hs && cyc < 50) begin
            @(negedge ACLK);
            hs = BVALID && BREADY;
            @(posedge ACLK); #1;
            cyc++;
        end
        if (!hs) checkOutput("b_timeout", 64'(0), 64'(1));
        checkOutput("b_done_valid", 64'(BVALID), 64'(0));
        checkOutput("b_done_ready", 64'({AWREADY, WREADY}), 64'(2'b11));
        checkOutput("reg0_live", 64'(o_REG0), 64'(model[0]));
    endtask

    task automatic readTxn(input logic [31:0] addr, input int rHold, input logic [2:0] prot);
        logic [33:0] expR;
        logic hs;
        int cyc;
        expR = expectRead(addr, prot);
        rq.push_back(expR);
        ARADDR = addr; ARPROT = prot; ARVALID = 1;
        RREADY = (rHold == 0);
        hs = 0; cyc = 0;
        while (!hs && cyc < 50) begin
            @(negedge ACLK);
            hs = ARREADY;
            @(posedge ACLK); #1;
            cyc++;
        end
        ARVALID = 0;
        if (!hs) checkOutput("ar_timeout", 64'(0), 64'(1));
        checkOutput("r_latency", 64'(RVALID), 64'(1));
        checkOutput("arready_low", 64'(ARREADY), 64'(0));
        for (int i = 0; i < rHold; i++) begin
            @(negedge ACLK);
            checkOutput("r_hold_valid", 64'(RVALID), 64'(1));
            checkOutput("r_hold_data", 64'({RRESP, RDATA}), 64'(expR));
            checkOutput("r_hold_ready", 64'(ARREADY), 64'(0));
        end
        if (rHold > 0) begin
            @(posedge ACLK); #1;
            RREADY = 1;
        end
        hs = 0; cyc = 0;
        while (!hs && cyc < 50) begin
            @(negedge ACLK);
            hs = RVALID && RREADY;
            @(posedge ACLK); #1;
            cyc++;
        end
        if (!hs) checkOutput("r_timeout", 64'(0), 64'(1));
        checkOutput("r_done_valid", 64'(RVALID), 64'(0));
        checkOutput("r_done_ready", 64'(ARREADY), 64'(1));
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_readies"}, 64'({AWREADY, WREADY, ARREADY}), 64'(3'b111));
        checkOutput({tag, "_valids"}, 64'({BVALID, RVALID}), 64'(0));
        checkOutput({tag, "_resps"}, 64'({BRESP, RRESP}), 64'(0));
        checkOutput({tag, "_rdata"}, 64'(RDATA), 64'(0));
        checkOutput({tag, "_reg0"}, 64'(o_REG0), 64'(0));
    endtask

    task automatic applyStimulus();
        logic [31:0] a, d;
        // Same-cycle AW/W write then readback
        writeTxn(32'h4, 32'hDEADBEEF, 4'hF, 0, 0, 0, 3'b001);
        readTxn(32'h4, 0, 3'b001);
        // W ahead of AW by three cycles, partial strobe over a preloaded word
        writeTxn(32'h8, 32'hFFFFFFFF, 4'hF, 0, 0, 0, 3'b001);
        writeTxn(32'h8, 32'h11223344, 4'b0101, 3, 0, 0, 3'b001);
        readTxn(32'h8, 0, 3'b001);
        checkOutput("reg2_merge_pattern", 64'(model[2]), 64'(32'hFF22FF44));
        // AW ahead of W, low address bits ignored, zero strobe is a no-op
        writeTxn(32'h7, 32'hCAFEF00D, 4'hF, 0, 2, 0, 3'b001);
        writeTxn(32'h4, 32'h0BADBEEF, 4'h0, 0, 0, 0, 3'b001);
        readTxn(32'h5, 0, 3'b001);
        // Out-of-range access and the last in-range word
        readTxn(32'h20, 0, 3'b001);
        writeTxn(32'h20, 32'h12345678, 4'hF, 0, 0, 0, 3'b001);
        writeTxn(32'h1C, 32'h87654321, 4'hF, 0, 0, 0, 3'b001);
        readTxn(32'h1C, 0, 3'b001);
        readTxn(32'h0, 0, 3'b001);
        // Backpressure on both response channels
        writeTxn(32'hC, 32'h5A5A0F0F, 4'hF, 0, 0, 5, 3'b001);
        readTxn(32'hC, 5, 3'b001);
        // Write commit and AR on the same edge: read returns the old value
        fork
            writeTxn(32'h0, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 3'b001);
            readTxn(32'h0, 0, 3'b001);
        join
        checkOutput("reg0_after_same_edge", 64'(o_REG0), 64'(32'hA5A5A5A5));
`ifdef AXIL_PROT_CHECK_EN
        writeTxn(32'h10, 32'h01020304, 4'hF, 0, 0, 0, 3'b000);
        readTxn(32'h10, 0, 3'b000);
        readTxn(32'h10, 0, 3'b001);
`endif
        // Random mix of writes and reads across and past the register range
        for (int i = 0; i < 12; i++) begin
            a = 32'($urandom_range(0, 39));
            d = $urandom();
            if ($urandom_range(0, 1) == 1)
                writeTxn(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 2), $urandom_range(0, 2),
                         $urandom_range(0, 2), 3'b001);
            else
                readTxn(a, $urandom_range(0, 2), 3'b001);
        end
        // Reset while both FSMs hold an unaccepted response
        BREADY = 0; RREADY = 0;
        AWADDR = 32'h0; AWPROT = 3'b001; WDATA = 32'h12345678; WSTRB = 4'hF; ARADDR = 32'h0; ARPROT = 3'b001;
        AWVALID = 1; WVALID = 1; ARVALID = 1;
        @(posedge ACLK); #1;
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        @(posedge ACLK); #1;
        checkOutput("pre_reset_valids", 64'({BVALID, RVALID}), 64'(2'b11));
        checkOutput("pre_reset_reg0", 64'(o_REG0), 64'(32'h12345678));
        ARESET = 1; #1;
        checkResetState("midreset");
        @(posedge ACLK); #1;
        ARESET = 0; BREADY = 1; RREADY = 1;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        @(posedge ACLK); #1;
        checkResetState("postreset");
        readTxn(32'h8, 0, 3'b001);
    endtask

    initial begin
        ARESET = 1;
        AWVALID = 0; WVALID = 0; ARVALID = 0; BREADY = 1; RREADY = 1;
        AWADDR = 0; ARADDR = 0; AWPROT = 0; ARPROT = 0; WDATA = 0; WSTRB = 0;
        for (int i = 0; i < NREGS; i++) model[i] = '0;
        repeat (2) @(posedge ACLK);
        #1;
        checkResetState("reset");
        ARESET = 0;
        @(posedge ACLK); #1;
        applyStimulus();
        repeat (2) @(posedge ACLK);
        checkOutput("bq_drained", 64'(bq.size()), 64'(0));
        checkOutput("rq_drained", 64'(rq.size()), 64'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
